// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int LINK_REG_DEF = 31;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_LD  = 2'b01;
  localparam logic [1:0] SRC_LNK = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] dst;
    logic [DW_DEF-1:0] data;
  } wb_req_t;

  // Round-robin successor: ALU -> LD -> LNK -> ALU.
  function automatic logic [1:0] next_src(input logic [1:0] src);
    case (src)
      SRC_ALU: next_src = SRC_LD;
      SRC_LD:  next_src = SRC_LNK;
      SRC_LNK: next_src = SRC_ALU;
      default: next_src = SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_port_arbiter_req_buf.sv
// One-entry holding buffer with valid/ready; a grant frees the slot in the
// same edge that a new request may refill it.
module wb_req_buf
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_dst,
  input  logic [DW-1:0] in_data,
  input  logic          grant,
  output logic          occ,
  output logic [AW-1:0] out_dst,
  output logic [DW-1:0] out_data
);

  logic          occ_q, occ_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready = ~occ_q | grant;
  assign occ      = occ_q;
  assign out_dst  = dst_q;
  assign out_data = data_q;

  // Capture on handshake, otherwise drain on grant.
  always_comb begin
    occ_d  = occ_q;
    dst_d  = dst_q;
    data_d = data_q;
    if (in_valid && in_ready) begin
      occ_d  = 1'b1;
      dst_d  = in_dst;
      data_d = in_data;
    end else if (grant) begin
      occ_d = 1'b0;
    end else begin
      occ_d = occ_q;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= 1'b0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      occ_q  <= occ_d;
      dst_q  <= dst_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU,
// load-return and call-link writers. Optional macro: WB_CONFLICT_CNT_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_dst,
  input  logic [DW-1:0] ld_data,
  input  logic          lnk_valid,
  output logic          lnk_ready,
  input  logic [DW-1:0] lnk_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [1:0]    rf_sel,
  output logic          busy
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam logic [AW-1:0] LINK_DST = AW'(LINK_REG);

  logic [2:0]    occ_s;
  logic [2:0]    grant_s;
  logic [AW-1:0] buf_dst_s [3];
  logic [DW-1:0] buf_data_s [3];

  logic          win_valid_s;
  logic [1:0]    win_src_s;
  logic [1:0]    srch_s;
  logic [AW-1:0] win_dst_s;
  logic [DW-1:0] win_data_s;

  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]    rf_sel_q, rf_sel_d;

  wb_req_buf #(.DW(DW), .AW(AW)) u_buf_alu (
    .clk(clk), .rst(rst), .in_valid(alu_valid), .in_ready(alu_ready),
    .in_dst(alu_dst), .in_data(alu_data), .grant(grant_s[0]),
    .occ(occ_s[0]), .out_dst(buf_dst_s[0]), .out_data(buf_data_s[0])
  );

  wb_req_buf #(.DW(DW), .AW(AW)) u_buf_ld (
    .clk(clk), .rst(rst), .in_valid(ld_valid), .in_ready(ld_ready),
    .in_dst(ld_dst), .in_data(ld_data), .grant(grant_s[1]),
    .occ(occ_s[1]), .out_dst(buf_dst_s[1]), .out_data(buf_data_s[1])
  );

  wb_req_buf #(.DW(DW), .AW(AW)) u_buf_lnk (
    .clk(clk), .rst(rst), .in_valid(lnk_valid), .in_ready(lnk_ready),
    .in_dst(LINK_DST), .in_data(lnk_data), .grant(grant_s[2]),
    .occ(occ_s[2]), .out_dst(buf_dst_s[2]), .out_data(buf_data_s[2])
  );

  // First occupied buffer in round-robin order starting at rr_ptr wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_src_s   = SRC_ALU;
    srch_s      = rr_ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (!win_valid_s && occ_s[srch_s]) begin
        win_valid_s = 1'b1;
        win_src_s   = srch_s;
      end else begin
        win_valid_s = win_valid_s;
      end
      srch_s = next_src(srch_s);
    end
    win_dst_s  = buf_dst_s[win_src_s];
    win_data_s = buf_data_s[win_src_s];
    grant_s    = win_valid_s ? (3'b001 << win_src_s) : 3'b000;
    rr_ptr_d   = win_valid_s ? next_src(win_src_s) : rr_ptr_q;
  end

  // Output stage; writes to register 0 still update addr/sel but never strobe.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_sel_d   = rf_sel_q;
    if (win_valid_s) begin
      rf_we_d    = (win_dst_s != '0);
      rf_waddr_d = win_dst_s;
      rf_wdata_d = win_data_s;
      rf_sel_d   = win_src_s;
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Arbiter pointer and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= SRC_ALU;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_sel_q   <= SRC_ALU;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_sel_q   <= rf_sel_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_sel   = rf_sel_q;
  assign busy     = (|occ_s) | rf_we_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        multi_occ_s;

  // Saturating count of cycles with two or more buffers waiting.
  always_comb begin
    multi_occ_s    = (occ_s[0] & occ_s[1]) | (occ_s[0] & occ_s[2]) | (occ_s[1] & occ_s[2]);
    conflict_cnt_d = conflict_cnt_q;
    if (multi_occ_s && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (optional WB_CONFLICT_CNT_EN tests).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_dst;
  logic [31:0] ld_data;
  logic        lnk_valid, lnk_ready;
  logic [31:0] lnk_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  rf_sel;
  logic        busy;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
    .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_data(lnk_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_sel(rf_sel),
    .busy(busy)
`ifdef WB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic test_reset();
    rst = 1'b0;
    alu_valid = 1'b0; alu_dst = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_dst  = 5'd0; ld_data  = 32'd0;
    lnk_valid = 1'b0; lnk_data = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({alu_ready, ld_ready, lnk_ready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b want 111", {alu_ready, ld_ready, lnk_ready});
    end
    checks++;
    if ({rf_we, busy, rf_sel} !== 4'b0000) begin
      errors++; $display("FAIL reset_we_busy_sel: got %b want 0000", {rf_we, busy, rf_sel});
    end
    checks++;
    if ({rf_waddr, rf_wdata} !== 37'd0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_all_three();
    logic [4:0]  exp_addr [3];
    logic [31:0] exp_data [3];
    logic [1:0]  exp_sel  [3];
    exp_addr[0] = 5'd3;  exp_data[0] = 32'h0000_0011; exp_sel[0] = 2'b00;
    exp_addr[1] = 5'd4;  exp_data[1] = 32'h0000_0022; exp_sel[1] = 2'b01;
    exp_addr[2] = 5'd31; exp_data[2] = 32'h0000_0033; exp_sel[2] = 2'b10;
    alu_valid = 1'b1; alu_dst = 5'd3; alu_data = 32'h0000_0011;
    ld_valid  = 1'b1; ld_dst  = 5'd4; ld_data  = 32'h0000_0022;
    lnk_valid = 1'b1; lnk_data = 32'h0000_0033;
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0; lnk_valid = 1'b0;
    checks++;
    if ({rf_we, busy} !== 2'b01) begin
      errors++; $display("FAIL all3_accept: we,busy got %b want 01", {rf_we, busy});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, rf_sel} !== {1'b1, exp_addr[k], exp_data[k], exp_sel[k]}) begin
        errors++;
        $display("FAIL all3_grant%0d: got we=%b addr=%0d data=%h sel=%b want we=1 addr=%0d data=%h sel=%b",
                 k, rf_we, rf_waddr, rf_wdata, rf_sel, exp_addr[k], exp_data[k], exp_sel[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ({rf_we, busy} !== 2'b00) begin
      errors++; $display("FAIL all3_idle: we,busy got %b want 00", {rf_we, busy});
    end
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'hA5A5_0001;
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL single_early: rf_we got %b want 0", rf_we);
    end
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, rf_sel} !== {1'b1, 5'd5, 32'hA5A5_0001, 2'b00}) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h sel=%b want we=1 addr=5 data=a5a50001 sel=00",
               rf_we, rf_waddr, rf_wdata, rf_sel);
    end
    @(negedge clk);
    checks++;
    if ({rf_we, busy, rf_waddr} !== {1'b0, 1'b0, 5'd5}) begin
      errors++; $display("FAIL single_oneshot: we=%b busy=%b addr=%0d want 0 0 5", rf_we, busy, rf_waddr);
    end
  endtask

  task automatic test_reg0();
    alu_valid = 1'b1; alu_dst = 5'd0; alu_data = 32'hDEAD_0000;
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reg0_busy: got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_sel} !== {1'b0, 5'd0, 2'b00}) begin
      errors++; $display("FAIL reg0_suppress: we=%b addr=%0d sel=%b want 0 0 00", rf_we, rf_waddr, rf_sel);
    end
    checks++;
    if ({alu_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL reg0_drain: ready,busy got %b want 10", {alu_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    int ai = 0;
    int li = 0;
    logic a_acc, l_acc;
    logic [1:0]  es;
    logic [4:0]  ea;
    logic [31:0] ed;
    for (int c = 1; c <= 10; c++) begin
      alu_valid = (c <= 8); alu_dst = 5'(8 + ai);  alu_data = 32'hA000_0000 + 32'(ai);
      ld_valid  = (c <= 8); ld_dst  = 5'(16 + li); ld_data  = 32'hB000_0000 + 32'(li);
      #1;
      a_acc = alu_valid & alu_ready;
      l_acc = ld_valid & ld_ready;
      @(posedge clk);
      if (a_acc) ai++;
      if (l_acc) li++;
      @(negedge clk);
      if (c >= 2) begin
        // Write c-2 in the expected stream l0,a0,l1,a1,... (pointer starts at LD).
        if (((c - 2) % 2) == 0) begin
          es = 2'b01; ea = 5'(16 + (c - 2) / 2); ed = 32'hB000_0000 + 32'((c - 2) / 2);
        end else begin
          es = 2'b00; ea = 5'(8 + (c - 3) / 2);  ed = 32'hA000_0000 + 32'((c - 3) / 2);
        end
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, rf_sel} !== {1'b1, ea, ed, es}) begin
          errors++;
          $display("FAIL b2b_write%0d: got we=%b addr=%0d data=%h sel=%b want we=1 addr=%0d data=%h sel=%b",
                   c - 2, rf_we, rf_waddr, rf_wdata, rf_sel, ea, ed, es);
        end
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if ((ai != 4) || (li != 5)) begin
      errors++; $display("FAIL b2b_accepts: alu=%0d ld=%0d want alu=4 ld=5", ai, li);
    end
    @(negedge clk);
    checks++;
    if ({rf_we, busy} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: we,busy got %b want 00", {rf_we, busy});
    end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_dst = 5'd7; alu_data = 32'h1111_2222;
    ld_valid  = 1'b1; ld_dst  = 5'd9; ld_data  = 32'h3333_4444;
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_full: busy got %b want 1", busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({rf_we, busy} !== 2'b00) begin
        errors++; $display("FAIL rstmid_no_write%0d: we,busy got %b want 00", k, {rf_we, busy});
      end
    end
  endtask

`ifdef WB_CONFLICT_CNT_EN
  task automatic test_conflict_cnt();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'd0) begin
      errors++; $display("FAIL cnt_reset: got %h want 0000", conflict_cnt);
    end
    alu_valid = 1'b1; alu_dst = 5'd1; alu_data = 32'h0;
    ld_valid  = 1'b1; ld_dst  = 5'd2; ld_data  = 32'h0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'd10) begin
      errors++; $display("FAIL cnt_ten: got %0d want 10", conflict_cnt);
    end
    alu_valid = 1'b1; ld_valid = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_saturate: got %h want ffff", conflict_cnt);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_all_three();
    test_single_alu();
    test_reg0();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_CONFLICT_CNT_EN
    test_conflict_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Controller for the register-file write port and its 5-bit destination-select mux (0 = ALU dest, 1 = load dest, 2/3 = link register).
- Shares the single write port between three requesters: ALU writeback, load-return unit and call-link writer.
- Each requester has a one-entry holding buffer. One write is granted per cycle using round-robin arbitration.
- Drives a registered write strobe, address, data and the mux select code.

Parameters:
- DW, 32, register data width.
- AW, 5, register address width.
- LINK_REG, 31, fixed destination index for link writes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write request.
- alu_ready  out  1  ALU buffer can accept.
- alu_dst  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- ld_valid  in  1  load-return write request.
- ld_ready  out  1  load buffer can accept.
- ld_dst  in  AW  load destination register.
- ld_data  in  DW  load data.
- lnk_valid  in  1  link write request.
- lnk_ready  out  1  link buffer can accept.
- lnk_data  in  DW  return address.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  write address.
- rf_wdata  out  DW  write data.
- rf_sel  out  2  dest-mux select: 00 ALU, 01 load, 10 link.
- busy  out  1  any buffer occupied or rf_we high.

Behaviour:
- Reset (rst low, async):
  - All buffers empty; rr_ptr = ALU.
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_sel=2'b00, busy=0.
  - All readys are 1 from the first cycle after reset release.
  - Reset mid-operation discards buffered writes; no rf_we is issued for them.
- Handshake:
  - A transfer occurs on a rising edge with X_valid & X_ready. The buffer captures dst/data.
  - X_ready = buffer empty OR buffer granted this cycle. This allows back-to-back accept, one per cycle per source.
  - valid must not depend on ready.
- Arbitration (combinational, cycle after capture):
  - Candidates are the occupied buffers.
  - Search order starts at rr_ptr: ALU -> LD -> LNK -> ALU.
  - The first occupied buffer wins. rr_ptr moves to the source after the winner.
  - rr_ptr holds when there is no grant.
  - The grant empties the winning buffer at the same edge.
- Output register:
  - On a grant edge: rf_we=1, rf_waddr = winner dst (LINK_REG for link), rf_wdata = winner data, rf_sel = winner code.
  - Otherwise rf_we=0; addr, data and sel hold their last values.
  - Latency: request accepted at edge N -> rf_we high in the cycle after edge N+1 (2 cycles) when uncontested.
- Register 0:
  - A grant whose dst = 0 consumes the buffer and updates addr/sel.
  - rf_we is forced to 0 for that grant.
- Ordering:
  - Same-source writes complete in acceptance order.
  - Cross-source order follows round-robin, including equal destinations. Hazard resolution is the pipeline's job.
- Worst-case wait: 2 grant cycles for any occupied buffer (no starvation).
- rf_sel never emits 2'b11.

Optional Feature:
- WB_CONFLICT_CNT_EN:
  - Defined: adds output conflict_cnt [15:0]. It counts cycles with ≥2 buffers occupied, saturates at 16'hFFFF and resets to 0.
  - Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package:
  - Source-code constants SRC_ALU=2'b00, SRC_LD=2'b01, SRC_LNK=2'b10.
  - Typedef for the write-request record (valid, dst, data).
  - LINK_REG default.
- Sub-module: wb_req_buf, the one-entry holding buffer with valid/ready. Instantiated three times; the link instance has its dst tied to LINK_REG.

Test Plan:
- Reset release -> all readys=1, rf_we=0, rf_sel=00; assert rst low mid-stream with two buffers full -> no rf_we afterwards.
- Single ALU write dst=5 data=32'hA5A5_0001 -> 2 cycles later rf_we=1, waddr=5, wdata=A5A5_0001, sel=00, for one cycle only.
- All three valid in the same cycle (alu dst 3, ld dst 4, lnk) with rr_ptr=ALU -> grants on consecutive cycles in order ALU, LD, LNK; waddr 3, 4, 31; sel 00, 01, 10.
- Continuous ALU + load valid for 8 cycles -> grants alternate ALU/LD; each source ready toggles so no accepted request is lost or reordered.
- ALU write dst=0 -> rf_we stays 0, buffer drains, alu_ready returns to 1.
- WB_CONFLICT_CNT_EN defined, two sources saturated for 10 cycles -> conflict_cnt = number of multi-occupied cycles; stuck sources for 70000 cycles -> counter saturates at FFFF.
